// File: rtl/breath_envelope_gen.sv
// breath_envelope_gen: trapezoidal rise/hold/fall/hold brightness envelope.
// The envelope value is only presented to the scan driver on frame_sync, so
// brightness never changes mid-frame.
// Latency: 1 clk from frame_sync to brightness change; no backpressure.
// Ports: clk, rst (sync, active-high), en (freezes prescaler/level/state),
//   frame_sync (row-wrap pulse), brightness/brightness_upd (latched output),
//   phase (0 RISE, 1 HOLD_HIGH, 2 FALL, 3 HOLD_LOW), cycle_done (period pulse).
// Optional: define BREATH_GAMMA_EN to gamma-correct the latched brightness.
module breath_envelope_gen #(
  parameter int WIDTH       = 8,
  parameter int STEP_CYCLES = 195312,
  parameter int HOLD_STEPS  = 16,
  parameter int MAX_LEVEL   = 255,
  parameter int MIN_LEVEL   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] brightness,
  output logic             brightness_upd,
  output logic [1:0]       phase,
  output logic             cycle_done
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int HW = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;
  localparam logic [CW-1:0]    CNT_LAST  = CW'(STEP_CYCLES - 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_STEPS);
  localparam logic [WIDTH-1:0] MAX_L     = WIDTH'(MAX_LEVEL);
  localparam logic [WIDTH-1:0] MIN_L     = WIDTH'(MIN_LEVEL);

  typedef enum logic [1:0] {
    RISE      = 2'd0,
    HOLD_HIGH = 2'd1,
    FALL      = 2'd2,
    HOLD_LOW  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] brightness_q, brightness_d;
  logic             upd_q, upd_d;
  logic             cycle_done_q, cycle_done_d;
  logic [1:0]       phase_q, phase_d;
  logic             step_tick;
  logic [WIDTH-1:0] latch_val;
`ifdef BREATH_GAMMA_EN
  logic [2*WIDTH-1:0] sq;
`endif

  always_comb begin
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    level_d      = level_q;
    state_d      = state_q;
    cycle_done_d = 1'b0;

    step_tick = en && (cnt_q == CNT_LAST);
    if (en) begin
      cnt_d = step_tick ? '0 : cnt_q + CW'(1);
    end

    if (step_tick) begin
      case (state_q)
        RISE: begin
          if (level_q < MAX_L) level_d = level_q + WIDTH'(1);
          if (level_d == MAX_L) state_d = (HOLD_STEPS == 0) ? FALL : HOLD_HIGH;
        end
        HOLD_HIGH: begin
          hold_d = hold_q + HW'(1);
          if (hold_d == HOLD_LAST) begin
            hold_d  = '0;
            state_d = FALL;
          end
        end
        FALL: begin
          if (level_q > MIN_L) level_d = level_q - WIDTH'(1);
          if (level_d == MIN_L) begin
            if (HOLD_STEPS == 0) begin
              state_d      = RISE;
              cycle_done_d = 1'b1;
            end else begin
              state_d = HOLD_LOW;
            end
          end
        end
        default: begin // HOLD_LOW
          hold_d = hold_q + HW'(1);
          if (hold_d == HOLD_LAST) begin
            hold_d       = '0;
            state_d      = RISE;
            cycle_done_d = 1'b1;
          end
        end
      endcase
    end

    // Latch uses the pre-step level, so a coincident step shows up one frame later.
`ifdef BREATH_GAMMA_EN
    // (l*l + 2^W-1) >> W: rounds up so any nonzero level stays visible.
    sq = {{WIDTH{1'b0}}, level_q} * {{WIDTH{1'b0}}, level_q}
         + {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
    latch_val = WIDTH'(sq >> WIDTH);
`else
    latch_val = level_q;
`endif
    brightness_d = frame_sync ? latch_val : brightness_q;
    upd_d        = frame_sync;
    phase_d      = state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RISE;
      cnt_q        <= '0;
      hold_q       <= '0;
      level_q      <= MIN_L;
      brightness_q <= MIN_L;
      upd_q        <= 1'b0;
      cycle_done_q <= 1'b0;
      phase_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      level_q      <= level_d;
      brightness_q <= brightness_d;
      upd_q        <= upd_d;
      cycle_done_q <= cycle_done_d;
      phase_q      <= phase_d;
    end
  end

  assign brightness     = brightness_q;
  assign brightness_upd = upd_q;
  assign phase          = phase_q;
  assign cycle_done     = cycle_done_q;

endmodule

// File: tb/tb_breath_envelope_gen.sv
module tb_breath_envelope_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       frame_sync = 1'b0;
  logic [7:0] brightness;
  logic       brightness_upd;
  logic [1:0] phase;
  logic       cycle_done;

  logic       rst_g = 1'b1;
  logic [7:0] brightness_g;
  logic       upd_g;
  logic [1:0] phase_g;
  logic       cycle_done_g;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  breath_envelope_gen #(
    .WIDTH(8), .STEP_CYCLES(4), .HOLD_STEPS(2), .MAX_LEVEL(7), .MIN_LEVEL(0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .frame_sync(frame_sync),
    .brightness(brightness), .brightness_upd(brightness_upd),
    .phase(phase), .cycle_done(cycle_done)
  );

  // Fast full-range instance, only meaningful with the gamma table built in.
  breath_envelope_gen #(
    .WIDTH(8), .STEP_CYCLES(1), .HOLD_STEPS(0), .MAX_LEVEL(255), .MIN_LEVEL(0)
  ) dut_g (
    .clk(clk), .rst(rst_g), .en(1'b1), .frame_sync(1'b1),
    .brightness(brightness_g), .brightness_upd(upd_g),
    .phase(phase_g), .cycle_done(cycle_done_g)
  );

  typedef struct {
    int cyc;   // clock edge after reset release at which frame_sync is high
    int val;   // brightness required after that edge
  } fs_vec_t;

  typedef struct {
    int cyc;
    int phase;
  } ph_vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change on negedge; outputs are sampled on the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; frame_sync = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  fs_vec_t fs_tab[11];
  ph_vec_t ph_tab[12];
  int      exp_b;
  int      nv;
  logic    fs_now;

  initial begin
    fs_tab[0]  = '{1, 0};   fs_tab[1]  = '{5, 1};   fs_tab[2]  = '{11, 2};
    fs_tab[3]  = '{21, 5};  fs_tab[4]  = '{29, 7};  fs_tab[5]  = '{31, 7};
    fs_tab[6]  = '{41, 6};  fs_tab[7]  = '{51, 4};  fs_tab[8]  = '{61, 1};
    fs_tab[9]  = '{65, 0};  fs_tab[10] = '{71, 0};

    ph_tab[0]  = '{4, 0};   ph_tab[1]  = '{27, 0};  ph_tab[2]  = '{28, 1};
    ph_tab[3]  = '{35, 1};  ph_tab[4]  = '{36, 2};  ph_tab[5]  = '{63, 2};
    ph_tab[6]  = '{64, 3};  ph_tab[7]  = '{71, 3};  ph_tab[8]  = '{72, 0};
    ph_tab[9]  = '{100, 1}; ph_tab[10] = '{108, 2}; ph_tab[11] = '{144, 0};

    @(negedge clk);
    do_reset();
    rst = 1'b1;
    step();
    chk("reset_brightness", int'(brightness), 0);
    chk("reset_upd", int'(brightness_upd), 0);
    chk("reset_phase", int'(phase), 0);
    chk("reset_cycle_done", int'(cycle_done), 0);
    rst = 1'b0;

    // Free run with a frame_sync schedule; brightness must only move on frame_sync.
    exp_b = 0;
    for (int k = 1; k <= 150; k++) begin
      fs_now = 1'b0;
      nv = 0;
      foreach (fs_tab[i]) if (fs_tab[i].cyc == k) begin
        fs_now = 1'b1;
        nv = fs_tab[i].val;
      end
      frame_sync = fs_now;
      step();
      if (fs_now) exp_b = nv;
      chk($sformatf("run_brightness@%0d", k), int'(brightness), exp_b);
      chk($sformatf("run_upd@%0d", k), int'(brightness_upd), int'(fs_now));
      chk($sformatf("run_cycle_done@%0d", k), int'(cycle_done), int'(k % 72 == 0));
      foreach (ph_tab[i]) if (ph_tab[i].cyc == k)
        chk($sformatf("run_phase@%0d", k), int'(phase), ph_tab[i].phase);
    end
    frame_sync = 1'b0;

    // frame_sync on the same edge as the 3->4 step latches 3; next one latches 4.
    do_reset();
    repeat (15) step();
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    chk("coincide_pre_step", int'(brightness), 3);
    repeat (3) step();
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    chk("coincide_next_frame", int'(brightness), 4);

    // Pause at level 4 with one prescaler count already used.
    do_reset();
    repeat (17) step();
    en = 1'b0;
    for (int k = 0; k < 50; k++) begin
      frame_sync = (k == 20);
      step();
      if (k == 20) begin
        chk("pause_relatch", int'(brightness), 4);
        chk("pause_upd", int'(brightness_upd), 1);
      end
      if (k == 21) chk("pause_upd_drop", int'(brightness_upd), 0);
    end
    frame_sync = 1'b0;
    chk("pause_phase", int'(phase), 0);
    en = 1'b1;
    step();
    step();
    frame_sync = 1'b1;
    step();
    chk("resume_tick_pre", int'(brightness), 4);
    step();
    frame_sync = 1'b0;
    chk("resume_level5", int'(brightness), 5);

    // Reset mid-FALL at level 6 overrides en and frame_sync.
    do_reset();
    repeat (40) step();
    frame_sync = 1'b1;
    step();
    chk("fall_level6", int'(brightness), 6);
    chk("fall_phase", int'(phase), 2);
    rst = 1'b1;
    step();
    chk("midreset_brightness", int'(brightness), 0);
    chk("midreset_phase", int'(phase), 0);
    chk("midreset_upd", int'(brightness_upd), 0);
    chk("midreset_cycle_done", int'(cycle_done), 0);
    rst = 1'b0;
    frame_sync = 1'b0;
    repeat (4) step();
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    chk("restart_level1", int'(brightness), 1);
    chk("restart_phase", int'(phase), 0);

`ifdef BREATH_GAMMA_EN
    begin
      fs_vec_t g_tab[5];
      g_tab[0] = '{1, 0};    // level 0
      g_tab[1] = '{2, 1};    // level 1
      g_tab[2] = '{17, 1};   // level 16
      g_tab[3] = '{129, 64}; // level 128
      g_tab[4] = '{256, 255};// level 255
      rst_g = 1'b1;
      step();
      rst_g = 1'b0;
      for (int k = 1; k <= 256; k++) begin
        step();
        foreach (g_tab[i]) if (g_tab[i].cyc == k)
          chk($sformatf("gamma@%0d", k), int'(brightness_g), g_tab[i].val);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
